// File: rtl/pcie_cc_pkt_arbiter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : pcie_cc_pkt_arbiter_pkg                                     |
// | Description : Shared types and constants for the PCIe CC packet arbiter: |
// |               AXI-stream keep-width helper, CC tuser width, arbiter FSM  |
// |               state encoding and pointer-width helper.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pcie_cc_pkt_arbiter_pkg;

  // Width of the Completer Completion tuser bus on the PCIe hard block.
  localparam int c_cc_tuser_width = 81;

  // tkeep carries one bit per DWORD of tdata.
  localparam int c_dword_bits = 32;

  // Arbiter FSM: IDLE picks a winner, BUSY forwards one whole TLP.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // tkeep width for a given tdata width (one bit per DWORD).
  function automatic int keep_width(input int data_width);
    return data_width / c_dword_bits;
  endfunction

  // Bits needed to hold a source index; never narrower than one bit.
  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cc_pkt_arbiter_rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : pcie_cc_pkt_arbiter_rr_pick                                 |
// | Description : Combinational rotate-priority picker. Returns the first    |
// |               requester found searching i_ptr, i_ptr+1, ... modulo       |
// |               NUM_REQ, as a one-hot vector and as an index.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcie_cc_pkt_arbiter_rr_pick
  import pcie_cc_pkt_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [PTR_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_pick,
  output logic [PTR_WIDTH-1:0] o_pick_idx,
  output logic                 o_any
);

  // One extra bit so ptr + offset (at most 2*NUM_REQ-2) never overflows
  // before the modulo wrap.
  localparam int c_sum_width = PTR_WIDTH + 1;

  logic [c_sum_width-1:0] w_sum;
  logic [PTR_WIDTH-1:0]   w_idx;

  // Walk offsets from the farthest to the nearest so the candidate closest
  // to the pointer is the one left standing.
  always_comb begin
    o_pick     = '0;
    o_pick_idx = '0;
    o_any      = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + c_sum_width'(k);
      if (w_sum >= c_sum_width'(NUM_REQ)) begin
        w_sum = w_sum - c_sum_width'(NUM_REQ);
      end
      w_idx = w_sum[PTR_WIDTH-1:0];
      if (i_req[w_idx]) begin
        o_pick        = '0;
        o_pick[w_idx] = 1'b1;
        o_pick_idx    = w_idx;
        o_any         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcie_cc_pkt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : pcie_cc_pkt_arbiter                                         |
// | Description : Packet-level round-robin arbiter sharing one PCIe CC       |
// |               AXI-stream between NUM_REQ completion sources. A grant is  |
// |               held from selection to the owner's tlast beat; per-source  |
// |               saturating packet counters are exported for debug.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcie_cc_pkt_arbiter
  import pcie_cc_pkt_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = keep_width(AXIS_DATA_WIDTH),
  parameter int AXIS_TUSER_WIDTH = c_cc_tuser_width,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_REQ*AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [NUM_REQ*AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_REQ-1:0]                    s_axis_tlast,
  input  logic [NUM_REQ-1:0]                    s_axis_tvalid,
  output logic [NUM_REQ-1:0]                    s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]          pkt_cnt
);

  localparam int c_ptr_width = ptr_width(NUM_REQ);

  arb_state_t               r_state;
  logic                     r_busy;
  logic [NUM_REQ-1:0]       r_grant;
  logic [c_ptr_width-1:0]   r_owner;
  logic [c_ptr_width-1:0]   r_ptr;

  logic [NUM_REQ-1:0]          w_pick;
  logic [c_ptr_width-1:0]      w_pick_idx;
  logic                        w_any;
  logic                        w_eop;
  logic [c_ptr_width-1:0]      w_next_ptr;

  logic [AXIS_DATA_WIDTH-1:0]  w_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]  w_tkeep;
  logic [AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic                        w_tlast;
  logic                        w_tvalid;

  // Winner selection uses the raw tvalid vector; it is only consulted in IDLE.
  pcie_cc_pkt_arbiter_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (c_ptr_width)
  ) u_rr_pick (
    .i_req      (s_axis_tvalid),
    .i_ptr      (r_ptr),
    .o_pick     (w_pick),
    .o_pick_idx (w_pick_idx),
    .o_any      (w_any)
  );

  // Forward the granted source's beat; with no grant everything reads zero,
  // which keeps m_axis_tvalid low in IDLE.
  always_comb begin
    w_tdata  = '0;
    w_tkeep  = '0;
    w_tuser  = '0;
    w_tlast  = 1'b0;
    w_tvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        w_tkeep  = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        w_tuser  = s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
        w_tlast  = s_axis_tlast[i];
        w_tvalid = s_axis_tvalid[i];
      end
    end
  end

  assign m_axis_tdata  = w_tdata;
  assign m_axis_tkeep  = w_tkeep;
  assign m_axis_tuser  = w_tuser;
  assign m_axis_tlast  = w_tlast;
  assign m_axis_tvalid = w_tvalid;

  // Only the owner sees the sink's ready; everyone else is held off.
  assign s_axis_tready = r_grant & {NUM_REQ{m_axis_tready}};

  // Final beat of the owned TLP is accepted this cycle.
  assign w_eop = (r_state == ST_BUSY) & w_tvalid & m_axis_tready & w_tlast;

  // Round-robin pointer moves to the source just after the finishing owner.
  assign w_next_ptr = (r_owner == c_ptr_width'(NUM_REQ - 1)) ? '0
                                                             : r_owner + c_ptr_width'(1);

  // Packet-level FSM: grant on request in IDLE, release on the owner's tlast.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BUSY;
            r_busy  <= 1'b1;
            r_grant <= w_pick;
            r_owner <= w_pick_idx;
          end
        end
        ST_BUSY: begin
          if (w_eop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

  // One saturating completed-packet counter per source.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pkt_cnt
      logic [CNT_WIDTH-1:0] r_cnt;

      // Count this source's finished TLPs, sticking at all-ones.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (w_eop && r_grant[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end

      assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pcie_cc_pkt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_pcie_cc_pkt_arbiter                                      |
// | Description : Self-checking bench for the PCIe CC packet arbiter with a  |
// |               per-cycle behavioural model and directed scenarios.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pcie_cc_pkt_arbiter;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int KW    = 2;
  localparam int UW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 64;
  localparam int LOGSZ = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [N-1:0]    grant;
  logic            busy;
  logic [N*CW-1:0] pkt_cnt;

  pcie_cc_pkt_arbiter #(
    .NUM_REQ          (N),
    .AXIS_DATA_WIDTH  (DW),
    .AXIS_KEEP_WIDTH  (KW),
    .AXIS_TUSER_WIDTH (UW),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant         (grant),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Source beat stores and control knobs
  logic [DW-1:0] q_data [N][DEPTH];
  logic [KW-1:0] q_keep [N][DEPTH];
  logic [UW-1:0] q_user [N][DEPTH];
  logic          q_last [N][DEPTH];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  stall;
  logic [N-1:0]  acc;
  logic          mready_ctl;
  logic          rst_ctl;

  // Output log
  int log_src  [LOGSZ];
  int log_pid  [LOGSZ];
  int log_beat [LOGSZ];
  int log_cyc  [LOGSZ];
  int log_n;
  int cyc;

  int n_checks;
  int n_pass;

  // Model state
  int mo_owner;
  int mo_ptr;
  int mo_cnt [N];
  int mo_c;
  bit mo_found;
  bit mo_started = 1'b0;

  logic [N-1:0]    exp_grant;
  logic [N-1:0]    exp_ready;
  logic            exp_valid;
  logic [N*CW-1:0] exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push_pkt(input int src, input int pid, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (tail[src] < DEPTH) begin
        q_data[src][tail[src]] = {8'(src), 8'(pid), 8'(b), 8'h5A, 32'($urandom)};
        q_keep[src][tail[src]] = 2'($urandom);
        q_user[src][tail[src]] = 8'($urandom);
        q_last[src][tail[src]] = (b == nbeats - 1);
        tail[src] = tail[src] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit idle();
    bit r;
    r = (busy === 1'b0);
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && !idle(); k++) step();
    check({tag, "_drained"}, 64'(idle()), 64'd1);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string tag);
    for (int k = 0; k < 50 && grant !== g; k++) step();
    check(tag, 64'(grant), 64'(g));
  endtask

  task automatic wait_log(input int n, input string tag);
    for (int k = 0; k < 100 && log_n < n; k++) step();
    check(tag, 64'(log_n >= n), 64'd1);
  endtask

  // Source drivers: retire accepted beats and present the next one.
  always @(posedge clk) begin
    #1;
    rst      = rst_ctl;
    m_tready = mready_ctl;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && head[i] < tail[i]) head[i] = head[i] + 1;
      if (head[i] < tail[i]) begin
        s_tvalid[i]              = ~stall[i];
        s_tdata[i*DW +: DW]      = q_data[i][head[i]];
        s_tkeep[i*KW +: KW]      = q_keep[i][head[i]];
        s_tuser[i*UW +: UW]      = q_user[i][head[i]];
        s_tlast[i]               = q_last[i][head[i]];
      end else begin
        s_tvalid[i]              = 1'b0;
        s_tdata[i*DW +: DW]      = '0;
        s_tkeep[i*KW +: KW]      = '0;
        s_tuser[i*UW +: UW]      = '0;
        s_tlast[i]               = 1'b0;
      end
    end
  end

  // Behavioural model: owner index (-1 when nobody owns), rotating pointer,
  // saturating per-source totals.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      mo_owner = -1;
      mo_ptr   = 0;
      for (int i = 0; i < N; i++) mo_cnt[i] = 0;
    end else if (mo_owner < 0) begin
      mo_found = 1'b0;
      for (int j = 0; j < N; j++) begin
        mo_c = (mo_ptr + j) % N;
        if (!mo_found && s_tvalid[mo_c]) begin
          mo_owner = mo_c;
          mo_found = 1'b1;
        end
      end
    end else if (s_tvalid[mo_owner] && m_tready && s_tlast[mo_owner]) begin
      if (mo_cnt[mo_owner] < (1 << CW) - 1) mo_cnt[mo_owner] = mo_cnt[mo_owner] + 1;
      mo_ptr   = (mo_owner + 1) % N;
      mo_owner = -1;
    end
    mo_started = 1'b1;
  end

  // Compare DUT against the model every cycle, log accepted output beats.
  always @(negedge clk) begin
    if (mo_started) begin
      exp_grant = '0;
      exp_ready = '0;
      exp_valid = 1'b0;
      if (mo_owner >= 0) begin
        exp_grant[mo_owner] = 1'b1;
        exp_valid           = s_tvalid[mo_owner];
        if (m_tready) exp_ready = exp_grant;
      end
      for (int s = 0; s < N; s++) exp_cnt[s*CW +: CW] = CW'(mo_cnt[s]);
      check("grant", 64'(grant), 64'(exp_grant));
      check("busy", 64'(busy), 64'(mo_owner >= 0));
      check("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
      check("s_tready", 64'(s_tready), 64'(exp_ready));
      check("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      if (exp_valid) begin
        check("m_tdata", m_tdata, s_tdata[mo_owner*DW +: DW]);
        check("m_tkeep", 64'(m_tkeep), 64'(s_tkeep[mo_owner*KW +: KW]));
        check("m_tuser", 64'(m_tuser), 64'(s_tuser[mo_owner*UW +: UW]));
        check("m_tlast", 64'(m_tlast), 64'(s_tlast[mo_owner]));
      end
    end
    acc = s_tvalid & s_tready;
    if (m_tvalid === 1'b1 && m_tready === 1'b1 && log_n < LOGSZ) begin
      log_src[log_n]  = int'(m_tdata[63:56]);
      log_pid[log_n]  = int'(m_tdata[55:48]);
      log_beat[log_n] = int'(m_tdata[47:40]);
      log_cyc[log_n]  = cyc;
      log_n           = log_n + 1;
    end
    cyc = cyc + 1;
  end

  int exp_cont_src  [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int exp_cont_beat [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_hold_src  [6]  = '{1, 1, 1, 1, 2, 2};
  int exp_hold_beat [6]  = '{0, 1, 2, 3, 0, 1};
  int n0;
  int idx0;
  int waited;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    log_n      = 0;
    cyc        = 0;
    rst        = 1'b0;
    rst_ctl    = 1'b0;
    mready_ctl = 1'b1;
    m_tready   = 1'b0;
    stall      = '0;
    acc        = '0;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tuser    = '0;
    s_tlast    = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset with every source already requesting
    for (int s = 0; s < N; s++) push_pkt(s, 1, 3);
    repeat (3) step();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // Contention: all four 3-beat packets served 0,1,2,3
    log_n   = 0;
    rst_ctl = 1'b1;
    drain("contention");
    check("cont_beats", 64'(log_n), 64'd12);
    for (int k = 0; k < 12; k++) begin
      check("cont_src", 64'(log_src[k]), 64'(exp_cont_src[k]));
      check("cont_beat", 64'(log_beat[k]), 64'(exp_cont_beat[k]));
    end
    for (int p = 1; p < 4; p++)
      check("cont_spacing", 64'(log_cyc[3*p] - log_cyc[3*(p-1)]), 64'd4);
    check("cont_pkt_cnt", 64'(pkt_cnt), 64'h1111);

    // Hold: source 1 stalls mid-packet while source 2 requests
    log_n = 0;
    push_pkt(1, 2, 4);
    wait_grant(4'b0010, "hold_grant");
    stall[1] = 1'b1;
    push_pkt(2, 2, 2);
    step();
    step();
    check("hold_grant_stalled", 64'(grant), 64'h2);
    check("hold_src2_ready", 64'(s_tready[2]), 64'd0);
    stall[1] = 1'b0;
    drain("hold");
    check("hold_beats", 64'(log_n), 64'd6);
    for (int k = 0; k < 6; k++) begin
      check("hold_src", 64'(log_src[k]), 64'(exp_hold_src[k]));
      check("hold_beat", 64'(log_beat[k]), 64'(exp_hold_beat[k]));
    end

    // Backpressure: sink ready toggles every cycle over a 4-beat packet
    log_n = 0;
    push_pkt(0, 3, 4);
    for (int k = 0; k < 60 && !idle(); k++) begin
      mready_ctl = ~mready_ctl;
      step();
    end
    mready_ctl = 1'b1;
    drain("bp");
    check("bp_beats", 64'(log_n), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("bp_src", 64'(log_src[k]), 64'd0);
      check("bp_beat", 64'(log_beat[k]), 64'(k));
    end

    // Fairness and saturation: source 3 streams, source 0 asks once
    log_n = 0;
    for (int p = 0; p < 20; p++) push_pkt(3, 8 + p, 1);
    wait_log(3, "fair_stream_started");
    push_pkt(0, 5, 1);
    n0 = log_n;
    drain("fair");
    idx0   = -1;
    waited = 0;
    for (int k = 0; k < log_n; k++) begin
      if (idx0 < 0 && log_src[k] == 0) idx0 = k;
    end
    for (int k = n0; k < idx0; k++) if (log_src[k] == 3) waited++;
    check("fair_src0_served", 64'(idx0 >= 0), 64'd1);
    check("fair_wait_le2", 64'(waited <= 2), 64'd1);
    check("sat_pkt_cnt", 64'(pkt_cnt), 64'hF223);

    // Reset mid-packet, with the pointer moved off zero beforehand
    push_pkt(1, 6, 1);
    drain("ptr_setup");
    log_n = 0;
    push_pkt(2, 7, 5);
    wait_log(2, "rmp_in_packet");
    rst_ctl = 1'b0;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    step();
    step();
    check("rmp_grant", 64'(grant), 64'd0);
    check("rmp_busy", 64'(busy), 64'd0);
    check("rmp_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rmp_pkt_cnt", 64'(pkt_cnt), 64'd0);
    rst_ctl = 1'b1;
    log_n   = 0;
    push_pkt(3, 9, 1);
    push_pkt(1, 9, 1);
    drain("post_rst");
    check("post_rst_beats", 64'(log_n), 64'd2);
    check("post_rst_first", 64'(log_src[0]), 64'd1);
    check("post_rst_second", 64'(log_src[1]), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
